// File: rtl/hash_collector.sv
// First-word-fall-through collector for 128-bit hashes with overflow detection and a saturating drop counter.
// Optional build macro HASH_DEDUP_EN suppresses an incoming hash equal to the last accepted one.
module hash_collector #(
  parameter int DEPTH      = 16,
  parameter int DROP_CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_valid,
  input  logic [127:0]            i_hash,
  output logic                    o_valid,
  output logic [127:0]            o_hash,
  input  logic                    i_ready,
  output logic [$clog2(DEPTH):0]  o_level,
  output logic                    o_overflow,
  input  logic                    i_clear_overflow,
  output logic [DROP_CNT_W-1:0]   o_drop_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [127:0]            mem_q [DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_next;
  logic [LVL_W-1:0]        level_q, level_d;
  logic                    valid_q, valid_d;
  logic [127:0]            hash_q, hash_d;
  logic                    overflow_q, overflow_d;
  logic [DROP_CNT_W-1:0]   drop_cnt_q, drop_cnt_d, drop_base;
  logic                    in_valid, full, push, pop, drop;
`ifdef HASH_DEDUP_EN
  logic [127:0]            last_hash_q, last_hash_d;
  logic                    last_v_q, last_v_d;
`endif

  always_comb begin
`ifdef HASH_DEDUP_EN
    in_valid = i_valid && !(last_v_q && (i_hash == last_hash_q));
`else
    in_valid = i_valid;
`endif
    pop      = valid_q && i_ready;
    full     = (level_q == LVL_W'(DEPTH));
    push     = in_valid && (!full || pop);
    drop     = in_valid && full && !pop;
    rd_next  = rd_ptr_q + PTR_W'(1);
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_next : rd_ptr_q;

    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    valid_d = (level_d != '0);

    // The head register always mirrors mem_q[rd_ptr_q]; an empty FIFO bypasses the array.
    hash_d = hash_q;
    if (pop) begin
      if (level_q > LVL_W'(1)) hash_d = mem_q[rd_next];
      else if (push)           hash_d = i_hash;
    end else if (!valid_q && push) begin
      hash_d = i_hash;
    end

    // A drop in the same cycle as a clear wins, leaving a count of one.
    drop_base  = i_clear_overflow ? '0 : drop_cnt_q;
    drop_cnt_d = (drop && !(&drop_base)) ? drop_base + DROP_CNT_W'(1) : drop_base;
    overflow_d = drop || (overflow_q && !i_clear_overflow);

`ifdef HASH_DEDUP_EN
    last_hash_d = push ? i_hash : last_hash_q;
    last_v_d    = push || last_v_q;
`endif
  end

  // NOTE: the storage array has no reset; every entry is written before the head can expose it.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= i_hash;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      valid_q    <= 1'b0;
      hash_q     <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
`ifdef HASH_DEDUP_EN
      last_hash_q <= '0;
      last_v_q    <= 1'b0;
`endif
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      valid_q    <= valid_d;
      hash_q     <= hash_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
`ifdef HASH_DEDUP_EN
      last_hash_q <= last_hash_d;
      last_v_q    <= last_v_d;
`endif
    end
  end

  assign o_valid      = valid_q;
  assign o_hash       = hash_q;
  assign o_level      = level_q;
  assign o_overflow   = overflow_q;
  assign o_drop_count = drop_cnt_q;

endmodule

// File: tb/tb_hash_collector.sv
// Self-checking bench for hash_collector: queue-based reference model compared every cycle,
// plus directed sequences with hand-computed literal expectations.
module tb_hash_collector;

  localparam int DEPTH      = 16;
  localparam int DROP_CNT_W = 16;
  localparam int DROP_MAX   = (1 << DROP_CNT_W) - 1;

  logic                   clk;
  logic                   rst;
  logic                   i_valid;
  logic [127:0]           i_hash;
  logic                   o_valid;
  logic [127:0]           o_hash;
  logic                   i_ready;
  logic [$clog2(DEPTH):0] o_level;
  logic                   o_overflow;
  logic                   i_clear_overflow;
  logic [DROP_CNT_W-1:0]  o_drop_count;

  int n_cmp = 0;
  int n_bad = 0;

  hash_collector #(.DEPTH(DEPTH), .DROP_CNT_W(DROP_CNT_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .i_valid          (i_valid),
    .i_hash           (i_hash),
    .o_valid          (o_valid),
    .o_hash           (o_hash),
    .i_ready          (i_ready),
    .o_level          (o_level),
    .o_overflow       (o_overflow),
    .i_clear_overflow (i_clear_overflow),
    .o_drop_count     (o_drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue holding what the consumer must eventually see.
  logic [127:0] mq[$];
  int           m_drop;
  bit           m_ovf;
  logic [127:0] m_last;
  bit           m_last_v;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      m_drop   = 0;
      m_ovf    = 1'b0;
      m_last   = '0;
      m_last_v = 1'b0;
    end else begin
      bit take, dup, do_pop, do_push, do_drop;
      dup = 1'b0;
`ifdef HASH_DEDUP_EN
      dup = m_last_v && (i_hash == m_last);
`endif
      take    = i_valid && !dup;
      do_pop  = (mq.size() != 0) && i_ready;
      do_push = take && (mq.size() < DEPTH || do_pop);
      do_drop = take && !do_push;
      if (i_clear_overflow) begin
        m_drop = 0;
        m_ovf  = 1'b0;
      end
      if (do_drop) begin
        m_ovf = 1'b1;
        if (m_drop < DROP_MAX) m_drop++;
      end
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        mq.push_back(i_hash);
        m_last   = i_hash;
        m_last_v = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    check("model_valid", 128'(o_valid), 128'(mq.size() != 0));
    check("model_level", 128'(o_level), 128'(mq.size()));
    if (mq.size() != 0) check("model_hash", o_hash, mq[0]);
    check("model_overflow", 128'(o_overflow), 128'(m_ovf));
    check("model_drop_count", 128'(o_drop_count), 128'(m_drop));
  end

  task automatic step(input logic v, input logic [127:0] h, input logic r, input logic clr);
    i_valid          = v;
    i_hash           = h;
    i_ready          = r;
    i_clear_overflow = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    i_valid = 1'b0; i_hash = '0; i_ready = 1'b0; i_clear_overflow = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    check("rst_valid", 128'(o_valid), 128'd0);
    check("rst_level", 128'(o_level), 128'd0);
    check("rst_hash", o_hash, 128'd0);
    check("rst_overflow", 128'(o_overflow), 128'd0);
    check("rst_drop_count", 128'(o_drop_count), 128'd0);

    // Three pushes with consumer stalled; head visible one cycle after the first push.
    step(1'b1, 128'h1, 1'b0, 1'b0);
    check("first_valid", 128'(o_valid), 128'd1);
    check("first_hash", o_hash, 128'h1);
    step(1'b1, 128'h2, 1'b0, 1'b0);
    step(1'b1, 128'h3, 1'b0, 1'b0);
    check("three_level", 128'(o_level), 128'd3);
    for (int k = 1; k <= 3; k++) begin
      check("drain3_hash", o_hash, 128'(k));
      step(1'b0, '0, 1'b1, 1'b0);
    end
    check("drain3_level", 128'(o_level), 128'd0);
    check("drain3_valid", 128'(o_valid), 128'd0);

    // Overflow: 20 pushes into 16 entries.
    for (int i = 0; i < 20; i++) step(1'b1, 128'h100 + 128'(i), 1'b0, 1'b0);
    check("ovf_level", 128'(o_level), 128'd16);
    check("ovf_flag", 128'(o_overflow), 128'd1);
    check("ovf_count", 128'(o_drop_count), 128'd4);
    // Full with simultaneous pop: push accepted, no drop.
    step(1'b1, 128'hBEEF, 1'b1, 1'b0);
    check("fullpop_level", 128'(o_level), 128'd16);
    check("fullpop_count", 128'(o_drop_count), 128'd4);
    for (int i = 1; i < 16; i++) begin
      check("ovf_readout", o_hash, 128'h100 + 128'(i));
      step(1'b0, '0, 1'b1, 1'b0);
    end
    check("fullpop_last", o_hash, 128'hBEEF);
    step(1'b0, '0, 1'b1, 1'b0);
    check("ovf_drained", 128'(o_level), 128'd0);

    // Clear behaviour, then clear colliding with a drop.
    for (int i = 0; i < 17; i++) step(1'b1, 128'h200 + 128'(i), 1'b0, 1'b0);
    check("count5", 128'(o_drop_count), 128'd5);
    step(1'b0, '0, 1'b0, 1'b1);
    check("clr_flag", 128'(o_overflow), 128'd0);
    check("clr_count", 128'(o_drop_count), 128'd0);
    step(1'b1, 128'h300, 1'b0, 1'b1);
    check("clrdrop_flag", 128'(o_overflow), 128'd1);
    check("clrdrop_count", 128'(o_drop_count), 128'd1);

    // Mid-stream asynchronous reset at level 7.
    for (int i = 0; i < 9; i++) step(1'b0, '0, 1'b1, 1'b0);
    check("pre_rst_level", 128'(o_level), 128'd7);
    i_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("async_rst_valid", 128'(o_valid), 128'd0);
    check("async_rst_level", 128'(o_level), 128'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    step(1'b1, 128'hA, 1'b0, 1'b0);
    check("post_rst_valid", 128'(o_valid), 128'd1);
    check("post_rst_hash", o_hash, 128'hA);
    step(1'b0, '0, 1'b1, 1'b0);

    // Back-to-back streaming with consumer always ready.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 128'h400 + 128'(i), 1'b1, 1'b0);
      check("stream_level", 128'(o_level), 128'd1);
      check("stream_hash", o_hash, 128'h400 + 128'(i));
    end
    step(1'b0, '0, 1'b1, 1'b0);
    check("stream_done", 128'(o_level), 128'd0);

    // Repeated hashes: suppressed only when deduplication is built in.
    step(1'b1, 128'h5, 1'b0, 1'b0);
    step(1'b1, 128'h5, 1'b0, 1'b0);
    step(1'b1, 128'h6, 1'b0, 1'b0);
    step(1'b1, 128'h5, 1'b0, 1'b0);
    i_valid = 1'b0;
`ifdef HASH_DEDUP_EN
    check("dedup_level", 128'(o_level), 128'd3);
    check("dedup_count", 128'(o_drop_count), 128'd0);
    check("dedup_h0", o_hash, 128'h5);
    step(1'b0, '0, 1'b1, 1'b0);
    check("dedup_h1", o_hash, 128'h6);
    step(1'b0, '0, 1'b1, 1'b0);
    check("dedup_h2", o_hash, 128'h5);
    step(1'b0, '0, 1'b1, 1'b0);
`else
    check("dup_level", 128'(o_level), 128'd4);
    check("dup_h0", o_hash, 128'h5);
    step(1'b0, '0, 1'b1, 1'b0);
    check("dup_h1", o_hash, 128'h5);
    step(1'b0, '0, 1'b1, 1'b0);
    check("dup_h2", o_hash, 128'h6);
    step(1'b0, '0, 1'b1, 1'b0);
    check("dup_h3", o_hash, 128'h5);
    step(1'b0, '0, 1'b1, 1'b0);
`endif
    check("final_level", 128'(o_level), 128'd0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
